// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit
// words and writes them sequentially from address 0 while holding the CPU.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start after reset; CPU held
// COLLECT | accepting bytes of the current word (byte_ready=1)
// WRITE   | one-cycle write strobe of the assembled word
// DONE    | session finished; CPU released, start may begin a new one
module imem_loader #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q;
    logic [7:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_q;
    logic [7:0]  len_clamped;
    logic [7:0]  word_idx_nxt;

    assign len_clamped  = (len_words > MAX_LEN) ? MAX_LEN : len_words;
    assign word_idx_nxt = word_idx + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len_clamped == 8'd0) ? DONE : COLLECT;
            end
            COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_cnt == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                mem_we  = 1'b1;
                busy    = 1'b1;
                state_d = (word_idx_nxt == len_q) ? DONE : COLLECT;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_d = (len_clamped == 8'd0) ? DONE : COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word index never reaches len_q (<= MAX_WORDS) in WRITE, so the address cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q     <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        len_q    <= len_clamped;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {asm_q, byte_data};
                            mem_addr  <= ADDR_W'({word_idx, 2'b00});
                        end else begin
                            asm_q <= {asm_q[15:0], byte_data};
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx_nxt;
                    byte_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
